// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: ID-stage hazard scoreboard bundle.
// Master drives the decoded ID instruction, slave returns forwarding/stall.
//
// Signals (master -> slave):
//   ID_valid, ID_kill, ID_wrEn, ID_rD, ID_is_load, ID_ppp,
//   ID_is_branch, ID_src (src0 in top slice), ID_src_used (src0 = MSB)
// Signals (slave -> master):
//   ID_fwd_sel (src0 in top slice), ID_stall,
//   ID_stall_cause {load, partial, branch}, stall_count
interface id_scoreboard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int SELW    = 2
) ();

  logic                     ID_valid;
  logic                     ID_kill;
  logic                     ID_wrEn;
  logic [REG_W-1:0]         ID_rD;
  logic                     ID_is_load;
  logic [2:0]               ID_ppp;
  logic                     ID_is_branch;
  logic [NUM_SRC*REG_W-1:0] ID_src;
  logic [NUM_SRC-1:0]       ID_src_used;

  logic [NUM_SRC*SELW-1:0]  ID_fwd_sel;
  logic                     ID_stall;
  logic [2:0]               ID_stall_cause;
  logic [15:0]              stall_count;

  modport master (
    output ID_valid, ID_kill, ID_wrEn, ID_rD,
    output ID_is_load, ID_ppp, ID_is_branch,
    output ID_src, ID_src_used,
    input  ID_fwd_sel, ID_stall,
    input  ID_stall_cause, stall_count
  );

  modport slave (
    input  ID_valid, ID_kill, ID_wrEn, ID_rD,
    input  ID_is_load, ID_ppp, ID_is_branch,
    input  ID_src, ID_src_used,
    output ID_fwd_sel, ID_stall,
    output ID_stall_cause, stall_count
  );

endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: tracks in-flight writers after ID, picks forwarding
// sources and raises load-use / partial-write / branch stalls.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - id_scoreboard_if.slave (ID instruction in, fwd/stall out)
// Stage k (1..PIPE_DEPTH) lives in slot_q[k-1]; fwd_sel value k means
// "forward from stage k", 0 means "read the register file".
module id_scoreboard #(
  parameter int REG_W        = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_READY   = 2,
  parameter int BR_MIN_STAGE = 2,
  parameter int SELW         = 2
) (
  input logic            clk,
  input logic            reset,
  id_scoreboard_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic             ld;
    logic             part;
  } slot_t;

  slot_t       slot_q [PIPE_DEPTH];
  slot_t       slot_in;
  logic [15:0] cnt_q;

  logic [REG_W-1:0] src_a [NUM_SRC];
  logic             used_a [NUM_SRC];
  logic             hit   [NUM_SRC];
  int               mk    [NUM_SRC];
  logic             mld   [NUM_SRC];
  logic             mpt   [NUM_SRC];

  logic                    hz_ld;
  logic                    hz_pt;
  logic                    hz_br;
  logic                    any_hz;
  logic                    issue;
  logic                    stall;
  logic [NUM_SRC*SELW-1:0] sel_c;

  // Source s sits in the top-most slice for s=0.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_a[g]  = bus.ID_src[(NUM_SRC-1-g)*REG_W +: REG_W];
    assign used_a[g] = bus.ID_src_used[NUM_SRC-1-g];
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      hit[s] = 1'b0;
      mk[s]  = 0;
      mld[s] = 1'b0;
      mpt[s] = 1'b0;
      for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
        if (slot_q[k].v && slot_q[k].wr &&
            slot_q[k].rd == src_a[s]) begin
          hit[s] = 1'b1;
          mk[s]  = k + 1;
          mld[s] = slot_q[k].ld;
          mpt[s] = slot_q[k].part;
        end
      end
    end
  end

  // Per-source resolution, first fitting rule wins.
  always_comb begin
    hz_ld = 1'b0;
    hz_pt = 1'b0;
    hz_br = 1'b0;
    sel_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (used_a[s] && hit[s]) begin
        if (mld[s] && mk[s] < LOAD_READY)
          hz_ld = 1'b1;
        else if (mpt[s])
          hz_pt = 1'b1;
        else if (bus.ID_is_branch &&
                 mk[s] < BR_MIN_STAGE)
          hz_br = 1'b1;
        else
          sel_c[(NUM_SRC-1-s)*SELW +: SELW] =
            SELW'(mk[s]);
      end
    end
  end

  assign issue  = bus.ID_valid & ~bus.ID_kill;
  assign any_hz = hz_ld | hz_pt | hz_br;
  assign stall  = issue & any_hz;

  assign bus.ID_stall       = stall;
  assign bus.ID_stall_cause = issue ?
                              {hz_ld, hz_pt, hz_br} : 3'b000;
  // A partially resolved operand set is useless, so all selects drop.
  assign bus.ID_fwd_sel     = any_hz ? '0 : sel_c;
  assign bus.stall_count    = cnt_q;

  always_comb begin
    slot_in = '0;
    if (issue && !stall) begin
      slot_in.v    = 1'b1;
      slot_in.wr   = bus.ID_wrEn;
      slot_in.rd   = bus.ID_rD;
      slot_in.ld   = bus.ID_is_load;
      slot_in.part = |bus.ID_ppp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++)
        slot_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      slot_q[0] <= slot_in;
      for (int k = 1; k < PIPE_DEPTH; k++)
        slot_q[k] <= slot_q[k-1];
      if (stall && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised hazard scoreboard for the ID stage. It tracks every in-flight register writer in the stages after ID and selects a forwarding source per ID source operand. It asserts an ID stall for three cases: load-use, partial (ppp) writes and branch-operand hazards. It replaces the single-stage EXMEM-only forwarding compare and sits beside the decoder and register file, driving the operand muxes and the IF/ID hold.

## Interface
Parameters:
- REG_W, 5: register address width.
- PIPE_DEPTH, 3: number of tracked stages after ID (1=EX … PIPE_DEPTH=WB).
- NUM_SRC, 2: number of source operands per instruction.
- LOAD_READY, 2: first stage index at which load data is forwardable.
- BR_MIN_STAGE, 2: first stage index a branch operand may be forwarded from.
- SELW, 2: forwarding-select width per source; must satisfy 2^SELW > PIPE_DEPTH.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- ID_valid, in, 1: ID holds a real instruction.
- ID_kill, in, 1: squash the ID instruction; it enters EX as a bubble and raises no stall.
- ID_wrEn, in, 1: ID instruction writes rD.
- ID_rD, in, [0:REG_W-1]: destination register.
- ID_is_load, in, 1: ID instruction is a load.
- ID_ppp, in, [0:2]: write-partition field; 3'b000 is a full 64-bit write, anything else is partial.
- ID_is_branch, in, 1: ID instruction is a branch resolved in ID.
- ID_src, in, [0:NUM_SRC*REG_W-1]: source addresses, src0 in the MSB-first (leftmost) slice.
- ID_src_used, in, [0:NUM_SRC-1]: per-source valid.
- ID_fwd_sel, out, [0:NUM_SRC*SELW-1]: per-source select; 0 = register file, k = stage k.
- ID_stall, out, 1: hold IF/ID and insert a bubble into EX.
- ID_stall_cause, out, [0:2]: {load, partial, branch}; any combination of bits may be set.
- stall_count, out, [0:15]: saturating count of stalled cycles.

## Operation
- **Tracking state.** Slots 1..PIPE_DEPTH each hold {v, wr, rd, ld, part}. On each posedge the slots shift k→k+1, and slot PIPE_DEPTH is discarded.
- **Slot 1 load value.** Slot 1 is loaded with the ID instruction when ID_valid & !ID_kill & !ID_stall. Otherwise slot 1 is loaded with a bubble (v=0).
  - The loaded fields are wr=ID_wrEn, rd=ID_rD, ld=ID_is_load, part=(ID_ppp!=0).
- **Per used source s, match search.** Find the smallest k such that slot k has v & wr & rd==src_s; only the youngest match counts. No register is special-cased: r0 is a normal register.
- **Source resolution.** Apply the first rule that fits:
  - No match: sel=0.
  - ld & k<LOAD_READY: load hazard.
  - part: partial hazard. Stall until the writer has left slot PIPE_DEPTH; the register file performs the merge.
  - ID_is_branch & k<BR_MIN_STAGE: branch hazard.
  - Otherwise: sel=k.
- **Hazard outputs.** While any hazard is present, all fwd_sel are 0. ID_stall is the OR of all causes across sources, gated by ID_valid & !ID_kill.
- **Kill vs hazard.** ID_kill overrides any hazard: stall=0 and cause=0.
- **Stall counter.** stall_count increments on every cycle with ID_stall=1 and holds at 16'hFFFF.

## Timing
- ID_fwd_sel, ID_stall and ID_stall_cause are combinational from the slots plus the ID inputs, all in the same cycle. There are no registered outputs apart from stall_count.
- Slot state and stall_count update only on the posedge.
- **Reset.** While reset is 1 at a posedge: all slot v=0 and stall_count=0. The reset value of each combinational output is a consequence of all v=0: ID_stall=0, ID_stall_cause=0, all ID_fwd_sel=0.
- **Reset mid-stall.** In-flight writers are dropped. From the next cycle no hazard is reported for them.
- **Load-use latency.** A dependent instruction directly behind a load stalls LOAD_READY-1 cycles (1 with defaults), then forwards from stage LOAD_READY.
- **Partial-write latency.** A partial write issued immediately before a consumer stalls that consumer PIPE_DEPTH cycles (3 with defaults), then it reads the register file (sel=0).
- **Simultaneous events.** When stall and a WB retirement happen in the same cycle, the bubble enters slot 1 and all other slots still shift. When multiple slots match, only the youngest decides.

## Test plan
- **Back-to-back ALU.** r3←(wr), then a consumer with src0=r3 → sel0=1, stall=0. One cycle later a consumer of r3 → sel0=2.
- **Load-use.** Load r5, then src1=r5 → stall=1 and cause=3'b100 for 1 cycle. Next cycle sel1=2 and stall=0. stall_count=1.
- **Partial write.** ppp=3'b011 write r7, then a consumer of r7 → stall for 3 cycles with cause=3'b010, then sel=0.
- **Branch.** ALU r2, then a branch on r2 → stall 1 cycle with cause=3'b001, then sel1=2.
- **Youngest wins / kill.** r4 is written at stage 3 and at stage 1 → sel=1. Load r4 followed by ID_kill on the consumer → stall=0 and slot 1 holds a bubble.
- **Reset.** Assert reset mid-load-stall → next cycle stall=0, stall_count=0, all sel=0. Holding stall for 70000 cycles → stall_count=16'hFFFF.
